score_tracker: RTL
==================

// Module: score_tracker
// PURPOSE
//  Producer side of the score path. Accumulates the player's in-game score from
//  hit/miss events and drives current_score to the all-time best-score tracker.
//  Applies a streak multiplier and saturates at the 8-bit maximum. Holds the
//  score frozen after game over so the best-score tracker sees a stable value.
// PARAMETERS
//  SCORE_W      8   width of current_score / alltime_highscore (saturates at 2^W-1)
//  STREAK_STEP  4   consecutive hits per multiplier increment
//  MAX_MULT     4   multiplier ceiling (>=1)
// PORTS
//  clk               in   1        system clock (50 MHz on DE2)
//  reset             in   1        synchronous, active-high reset
//  startGameEn       in   1        1-cycle pulse: begin new game, clear score
//  gameOverEn        in   1        1-cycle pulse: end current game, freeze score
//  hitEn             in   1        1-cycle pulse: player scored a hit
//  hit_points        in   4        base points for this hit, sampled with hitEn
//  missEn            in   1        1-cycle pulse: player missed; breaks streak
//  alltime_highscore in   SCORE_W  best score so far (from best-score tracker)
//  current_score     out  SCORE_W  running score of the current game
//  streak            out  4        consecutive-hit count, saturates at 15
//  multiplier        out  3        active multiplier, 1..MAX_MULT
//  game_active       out  1        high while in PLAYING
//  new_best          out  1        current_score > alltime_highscore this game
// BEHAVIOUR
//  Reset (reset=1 at posedge clk): state=IDLE; current_score=0, streak=0,
//   multiplier=1, game_active=0, new_best=0. Reset overrides all inputs.
//  States: IDLE -> PLAYING on startGameEn. PLAYING -> OVER on gameOverEn.
//   OVER -> PLAYING on startGameEn. startGameEn from any state: clear
//   current_score, streak, new_best; multiplier=1; enter PLAYING next cycle.
//  Priority per cycle: reset > startGameEn > gameOverEn > hitEn/missEn.
//   gameOverEn with hitEn in same cycle: hit discarded, score frozen as-is.
//  Hit (PLAYING, hitEn=1): current_score <= min(current_score +
//   hit_points*multiplier, 2^SCORE_W-1), using multiplier value BEFORE this
//   hit. Sum computed at SCORE_W+3 bits to detect overflow; no wrap-around.
//   streak <= min(streak+1, 15). Latency: 1 clk from hitEn to updated score.
//  hit_points=0 with hitEn: score unchanged, streak still increments.
//  Miss (PLAYING, missEn=1): streak <= 0. hitEn and missEn together: points
//   added with pre-miss multiplier, then streak <= 0.
//  multiplier: registered, = min(1 + streak/STREAK_STEP, MAX_MULT), updated
//   the cycle after streak changes (tracks new streak value).
//  IDLE/OVER: hitEn, missEn, gameOverEn ignored; all outputs hold.
//  new_best: registered; set when in PLAYING and current_score >
//   alltime_highscore; sticky until startGameEn or reset; holds in OVER.
//   Equality does not set it.
//  game_active = (state==PLAYING), registered output.
// TESTING
//  1 reset, startGameEn, 3 hits hit_points=5 -> current_score 5,10,15, mult=1,
//    game_active=1 one cycle after start.
//  2 8 consecutive hits pts=1 (STREAK_STEP=4) -> score 1,2,3,4,6,8,10,12, mult 3
//    after 8th; missEn -> streak 0, mult returns to 1 next cycle.
//  3 score 250, mult 4, hit pts=15 -> current_score saturates at 255, no wrap;
//    further hits keep 255.
//  4 alltime_highscore=20, score 18 -> hit pts=2 (20) new_best=0; next hit
//    pts=1 (21) -> new_best=1, stays 1 after gameOverEn.
//  5 gameOverEn with hitEn same cycle -> score unchanged, game_active=0;
//    hits in OVER ignored; startGameEn -> score 0, new_best 0, PLAYING.
//  6 reset asserted mid-game (score 100, streak 7) -> all outputs to reset
//    values next edge; hits ignored until startGameEn.

Source files
------------

// File: rtl/score_tracker.sv
// score_tracker: per-game score accumulator with streak multiplier, saturation and new-best flag
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   startGameEn             pulse: clear score/streak/new_best and enter PLAYING
//   gameOverEn              pulse: leave PLAYING and freeze the score
//   hitEn, hit_points       pulse plus base points (scaled by the current multiplier)
//   missEn                  pulse: clear the streak
//   alltime_highscore       best score so far, compared for new_best
//   current_score           saturating running score
//   streak, multiplier      consecutive-hit count (max 15) and active multiplier
//   game_active, new_best   PLAYING indicator and sticky beat-the-best flag
module score_tracker #(
  parameter int SCORE_W     = 8,
  parameter int STREAK_STEP = 4,
  parameter int MAX_MULT    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startGameEn,
  input  logic               gameOverEn,
  input  logic               hitEn,
  input  logic [3:0]         hit_points,
  input  logic               missEn,
  input  logic [SCORE_W-1:0] alltime_highscore,
  output logic [SCORE_W-1:0] current_score,
  output logic [3:0]         streak,
  output logic [2:0]         multiplier,
  output logic               game_active,
  output logic               new_best
);
  typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_e;
  localparam logic [SCORE_W+2:0] MAX_SCORE = {3'b000, {SCORE_W{1'b1}}};
  localparam logic [3:0] STEP = 4'(STREAK_STEP);
  localparam logic [4:0] MMAX = 5'(MAX_MULT);
  state_e state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0] streak_q, streak_d;
  logic [2:0] mult_q, mult_d;
  logic best_q, best_d;
  logic [6:0] prod;
  logic [SCORE_W+2:0] sum;
  logic [4:0] mult_raw;
  // The multiplier is registered alongside the streak it is derived from, so
  // a hit always scales with the multiplier that was in effect before it.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    streak_d = streak_q;
    best_d   = best_q;
    prod     = hit_points * mult_q;
    sum      = (SCORE_W+3)'(score_q) + (SCORE_W+3)'(prod);
    if (startGameEn) begin
      state_d  = PLAYING;
      score_d  = '0;
      streak_d = '0;
      best_d   = 1'b0;
    end else if (state_q == PLAYING) begin
      best_d = best_q | (score_q > alltime_highscore);
      if (gameOverEn) state_d = OVER;
      else begin
        if (hitEn) score_d = sum > MAX_SCORE ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
        streak_d = missEn ? 4'd0 : hitEn ? (streak_q == 4'd15 ? 4'd15 : streak_q + 4'd1) : streak_q;
      end
    end
    mult_raw = 5'd1 + {1'b0, streak_d / STEP};
    mult_d   = mult_raw > MMAX ? MMAX[2:0] : mult_raw[2:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      score_q  <= '0;
      streak_q <= '0;
      mult_q   <= 3'd1;
      best_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      streak_q <= streak_d;
      mult_q   <= mult_d;
      best_q   <= best_d;
    end
  end
  assign current_score = score_q;
  assign streak        = streak_q;
  assign multiplier    = mult_q;
  assign game_active   = state_q == PLAYING;
  assign new_best      = best_q;
endmodule
